serial_adder: RTL
=================

// Module: serial_adder
// PURPOSE
//  Multi-cycle, digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits per
//  clock through one DIGIT-wide carry-propagate slice with a registered carry. Trades latency
//  for area in arithmetic datapaths. Valid/ready on both sides; signed overflow flag.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=2)
//  DIGIT  1  bits processed per clock; must divide WIDTH (1 = bit-serial)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand bundle valid
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  ci         in   1      carry-in (borrow-in when sub=1)
//  sub        in   1      0: A+B+ci ; 1: A-B-ci
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  s          out  WIDTH  sum/difference
//  co         out  1      raw carry-out of MSB (sub: 1 = no borrow)
//  ovf        out  1      two's-complement overflow
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, count 0, carry 0; s=0, co=0, ovf=0, out_valid=0,
//   in_ready=1, busy=0. Takes effect immediately, also mid-RUN/DONE; operation discarded.
//  N = WIDTH/DIGIT. FSM: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: in_ready=1. Edge with in_valid=1: latch a, b^{WIDTH{sub}}, carry=ci^sub, MSB
//   operand bits for ovf, count=0; go RUN. in_valid=0: stay.
//  RUN: in_ready=0. Each edge adds digit [count*DIGIT +: DIGIT] of A and effective B plus
//   carry, stores DIGIT sum bits in result shift reg, updates carry, count++. Inputs a,b,
//   ci, sub, in_valid ignored while not IDLE.
//  After N-th RUN edge: s=result, co=final carry, ovf=(A[W-1]==Beff[W-1])&&(s[W-1]!=A[W-1]),
//   out_valid=1, state DONE. out_valid rises exactly N edges after accepting edge.
//  DONE: out_valid=1, s/co/ovf stable. Edge with out_ready=1: out_valid=0, go IDLE (next
//   accept no earlier than following edge; throughput one op per N+2 cycles). out_ready=0:
//   hold indefinitely.
//  s/co/ovf change only on entry to DONE (or reset); hold last result in IDLE/RUN.
//  Width rules: result modulo 2^WIDTH; carry beyond MSB only in co. DIGIT=WIDTH -> N=1.
//  out_ready while not DONE: ignored. X on a/b outside IDLE-accept: must not propagate.
//  Illegal parameters (WIDTH%DIGIT!=0, WIDTH<2): elaboration-time error.
// TESTING  (WIDTH=8, DIGIT=1 unless noted)
//  T1 add wrap: a=0xFF,b=0x01,ci=0,sub=0 -> s=0x00,co=1,ovf=0; out_valid 8 edges after accept
//  T2 subtract: a=0x05,b=0x07,ci=0,sub=1 -> s=0xFE,co=0,ovf=0; a=0x07,b=0x05 -> s=0x02,co=1
//  T3 overflow: a=0x7F,b=0x01,ci=0 -> s=0x80,co=0,ovf=1; a=0x80,b=0x01,sub=1 -> s=0x7F,ovf=1
//  T4 backpressure: out_ready=0 for 5 cycles in DONE -> s/co/ovf/out_valid stable, in_ready=0;
//   new in_valid ignored; out_ready=1 -> IDLE next edge, in_ready=1
//  T5 reset mid-RUN: rst_n=0 at count=3 -> outputs zero immediately; later a=0x10,b=0x20 -> s=0x30
//  T6 DIGIT=4 and DIGIT=8: a=0x3C,b=0xC4,ci=1 -> s=0x01,co=1; latency 2 and 1 edges; random
//   10k ops all configs vs behavioural {co,s}=a+-b+-ci model

Source files
------------

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: WIDTH-bit operands consumed DIGIT bits per clock through one
// DIGIT-wide carry-propagate slice with a registered carry; valid/ready on both sides.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if ((DIGIT < 1) || (WIDTH < 2) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
    $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]    count;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic [DIGIT:0]   dsum;
  logic             last;
  int               dig_idx;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and out_valid stays high until the consumer takes it.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign state_dbg = state;
  assign last      = (count == CW'(N - 1));

  // b_q holds the effective operand (already inverted for subtract), so one slice serves both.
  always_comb begin
    dig_idx  = int'(count) * DIGIT;
    dsum     = {1'b0, a_q[dig_idx +: DIGIT]} + {1'b0, b_q[dig_idx +: DIGIT]}
             + {{DIGIT{1'b0}}, carry};
    res_next = res;
    res_next[dig_idx +: DIGIT] = dsum[DIGIT-1:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      res   <= '0;
      s     <= '0;
      co    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b ^ {WIDTH{sub}};
            carry <= ci ^ sub;
            count <= '0;
          end
        end
        RUN: begin
          res   <= res_next;
          carry <= dsum[DIGIT];
          count <= count + 1'b1;
          if (last) begin
            s   <= res_next;
            co  <= dsum[DIGIT];
            ovf <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_next[WIDTH-1] != a_q[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
